// File: rtl/sw_display_pkg.sv
// rtl/sw_display_pkg.sv - segment patterns, display FSM states and width helpers for sw_result_display
package sw_display_pkg;

  typedef logic [6:0] seg_t;

  // Active-low, bit order g..a
  localparam seg_t SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam seg_t SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, CONV, SHOW} disp_state_e;

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : $clog2(n);
  endfunction

  // Decimal digits needed to print 2**w-1
  function automatic int unsigned dec_digits(input int unsigned w);
    longint unsigned v;
    int unsigned d;
    v = (64'd1 << w) - 64'd1;
    d = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_double_dabble.sv
// rtl/bcd_double_dabble.sv - sequential binary-to-BCD converter, one shift per cycle, DATA_W cycles per run
module bcd_double_dabble
  import sw_display_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int DIGITS = 8
) (
  input  logic                  CLOCK,
  input  logic                  RST_N,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_bin,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int CNT_W = safe_clog2(DATA_W + 1);

  logic [DATA_W-1:0] sh;
  logic [CNT_W-1:0]  cnt;

  function automatic logic [4*DIGITS-1:0] dabble(input logic [4*DIGITS-1:0] bcd, input logic bit_in);
    logic [4*DIGITS-1:0] adj;
    adj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end
    return {adj[4*DIGITS-2:0], bit_in};
  endfunction

  // The start cycle already performs the first shift, so a run is exactly DATA_W cycles
  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      sh     <= '0;
      cnt    <= '0;
      o_bcd  <= '0;
      o_done <= 1'b0;
    end else if (i_start) begin
      o_bcd  <= dabble('0, i_bin[DATA_W-1]);
      sh     <= i_bin << 1;
      cnt    <= CNT_W'(DATA_W - 1);
      o_done <= (DATA_W == 1);
    end else if (cnt != '0) begin
      o_bcd  <= dabble(o_bcd, sh[DATA_W-1]);
      sh     <= sh << 1;
      cnt    <= cnt - CNT_W'(1);
      o_done <= (cnt == CNT_W'(1));
    end else begin
      o_done <= 1'b0;
    end
  end

endmodule

// File: rtl/sw_result_display.sv
// rtl/sw_result_display.sv - score history, debounced paging key and 7-segment hex/decimal viewer
// Optional build macro SW_LEADING_ZERO_BLANK_EN blanks zero digits above the leading nonzero digit.
module sw_result_display
  import sw_display_pkg::*;
#(
  parameter int DATA_W  = 18,
  parameter int DEPTH   = 4,
  parameter int DIGITS  = 8,
  parameter int DEB_CYC = 500000
) (
  input  logic                     CLOCK,
  input  logic                     RST_N,
  input  logic                     i_valid,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_key_n,
  input  logic                     i_dec,
  output logic [DIGITS*7-1:0]      o_seven,
  output logic [DATA_W-1:0]        o_score,
  output logic [$clog2(DEPTH)-1:0] o_sel,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int DEB_W = safe_clog2(DEB_CYC);

  if (DIGITS < dec_digits(DATA_W)) begin : g_digits_check
    $error("sw_result_display: DIGITS=%0d cannot hold 2**%0d-1 in decimal", DIGITS, DATA_W);
  end

`ifdef SW_LEADING_ZERO_BLANK_EN
  localparam seg_t SEG_UPPER_RST = SEG_BLANK;
`else
  localparam seg_t SEG_UPPER_RST = SEG_HEX[0];
`endif

  function automatic logic [DIGITS*7-1:0] reset_seven();
    logic [DIGITS*7-1:0] s;
    for (int k = 0; k < DIGITS; k++) s[7*k +: 7] = (k == 0) ? SEG_HEX[0] : SEG_UPPER_RST;
    return s;
  endfunction

  localparam logic [DIGITS*7-1:0] SEVEN_RST = reset_seven();

  // Key synchroniser and debouncer
  logic             key_s1, key_s2, key_armed, key_pulse;
  logic [DEB_W-1:0] deb_cnt;

  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      key_s1    <= 1'b1;
      key_s2    <= 1'b1;
      key_armed <= 1'b1;
      key_pulse <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      key_s1    <= i_key_n;
      key_s2    <= key_s1;
      key_pulse <= 1'b0;
      // armed waits for DEB_CYC lows, disarmed waits for DEB_CYC highs
      if (key_s2 == key_armed) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
        deb_cnt   <= '0;
        key_armed <= ~key_armed;
        key_pulse <= key_armed;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // History ring
  logic [DATA_W-1:0] hist [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    sel_inc;

  assign sel_inc = {1'b0, o_sel} + (PTR_W+1)'(1);
  assign rd_ptr  = wr_ptr - PTR_W'(1) - o_sel;
  assign o_score = (o_count == '0) ? '0 : hist[rd_ptr];

  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      wr_ptr  <= '0;
      o_count <= '0;
      o_sel   <= '0;
    end else if (i_valid) begin
      hist[wr_ptr] <= i_data;
      wr_ptr       <= wr_ptr + PTR_W'(1);
      o_sel        <= '0;
      if (o_count != (PTR_W+1)'(DEPTH)) o_count <= o_count + (PTR_W+1)'(1);
    end else if (key_pulse && o_count > (PTR_W+1)'(1)) begin
      o_sel <= (sel_inc == o_count) ? '0 : sel_inc[PTR_W-1:0];
    end
  end

  // Display FSM
  disp_state_e         state, state_nxt;
  logic                fresh, snap_dec, dd_start, dd_done, load;
  logic [DATA_W-1:0]   snap_score;
  logic [4*DIGITS-1:0] dd_bcd, nibbles;
  logic [DIGITS*7-1:0] seven_nxt;
  logic [3:0]          nib;
`ifdef SW_LEADING_ZERO_BLANK_EN
  logic                seen;
`endif

  bcd_double_dabble #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_dd (
    .CLOCK   (CLOCK),
    .RST_N   (RST_N),
    .i_start (dd_start),
    .i_bin   (o_score),
    .o_done  (dd_done),
    .o_bcd   (dd_bcd)
  );

  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      fresh      <= 1'b1;
      snap_score <= '0;
      snap_dec   <= 1'b0;
      o_seven    <= SEVEN_RST;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == CONV) begin
        snap_score <= o_score;
        snap_dec   <= i_dec;
        fresh      <= 1'b0;
      end
      if (load) o_seven <= seven_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dd_start  = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: if (fresh || o_score != snap_score || i_dec != snap_dec) begin
        state_nxt = CONV;
        dd_start  = i_dec;
      end
      CONV: if (!snap_dec || dd_done) begin
        state_nxt = SHOW;
        load      = 1'b1;
      end
      SHOW:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy = (state == CONV) && snap_dec;

  always_comb begin
    seven_nxt = '0;
    nib       = '0;
    nibbles   = snap_dec ? dd_bcd : (4*DIGITS)'(snap_score);
`ifdef SW_LEADING_ZERO_BLANK_EN
    seen = 1'b0;
`endif
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nib = nibbles[4*k +: 4];
`ifdef SW_LEADING_ZERO_BLANK_EN
      seen = seen || (nib != 4'd0) || (k == 0);
      seven_nxt[7*k +: 7] = seen ? SEG_HEX[nib] : SEG_BLANK;
`else
      seven_nxt[7*k +: 7] = SEG_HEX[nib];
`endif
    end
  end

endmodule

// File: tb/tb_sw_result_display.sv
// tb/tb_sw_result_display.sv - self-checking bench for sw_result_display (honours SW_LEADING_ZERO_BLANK_EN)
module tb_sw_result_display;

  localparam int DATA_W  = 18;
  localparam int DEPTH   = 4;
  localparam int DIGITS  = 8;
  localparam int DEB_CYC = 8;
  localparam int SETTLE  = 60;

  logic                 CLOCK = 1'b0;
  logic                 RST_N;
  logic                 i_valid, i_key_n, i_dec;
  logic [DATA_W-1:0]    i_data;
  logic [DIGITS*7-1:0]  o_seven;
  logic [DATA_W-1:0]    o_score;
  logic [1:0]           o_sel;
  logic [2:0]           o_count;
  logic                 o_busy;

  sw_result_display #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIGITS(DIGITS), .DEB_CYC(DEB_CYC)) dut (
    .CLOCK   (CLOCK),
    .RST_N   (RST_N),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_key_n (i_key_n),
    .i_dec   (i_dec),
    .o_seven (o_seven),
    .o_score (o_score),
    .o_sel   (o_sel),
    .o_count (o_count),
    .o_busy  (o_busy)
  );

  always #5 CLOCK = ~CLOCK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; 15: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [DIGITS*7-1:0] exp_seven(input longint unsigned v, input bit dec);
    logic [DIGITS*7-1:0] r;
    longint unsigned base, p;
    base = dec ? 64'd10 : 64'd16;
    p = 64'd1;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[7*k +: 7] = seg(int'((v / p) % base));
`ifdef SW_LEADING_ZERO_BLANK_EN
      if (k > 0 && v < p) r[7*k +: 7] = 7'h7F;
`endif
      p = p * base;
    end
    return r;
  endfunction

  // Reference model: every score ever captured, newest at the back
  int unsigned hq[$];
  int msel;

  function automatic int mcount();
    return (hq.size() > DEPTH) ? DEPTH : hq.size();
  endfunction

  function automatic int unsigned mscore();
    return (hq.size() == 0) ? 0 : hq[hq.size() - 1 - msel];
  endfunction

  task automatic do_valid(input logic [DATA_W-1:0] d);
    i_valid = 1'b1;
    i_data  = d;
    tick();
    i_valid = 1'b0;
    hq.push_back(d);
    msel = 0;
  endtask

  task automatic do_key();
    i_key_n = 1'b0;
    tick(DEB_CYC + 6);
    i_key_n = 1'b1;
    tick(DEB_CYC + 6);
    if (mcount() > 1) msel = (msel + 1) % mcount();
  endtask

  task automatic check_model(input string tag);
    check({tag, "_score"}, o_score, mscore());
    check({tag, "_sel"},   o_sel,   msel);
    check({tag, "_count"}, o_count, mcount());
    check({tag, "_seven"}, o_seven, exp_seven(mscore(), i_dec));
  endtask

  typedef struct {
    bit                key;
    bit                dec;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] score;
    int                sel;
    int                cnt;
  } vec_t;

  vec_t tbl[16];
  int   lat;
  int   busy_n;
  bit   seen_busy, held_ok;
  logic [DIGITS*7-1:0] prev_seven;

  initial begin
    tbl[0]  = '{0, 0, 18'h00012, 18'h00012, 0, 1};
    tbl[1]  = '{0, 0, 18'h3FFFF, 18'h3FFFF, 0, 2};
    tbl[2]  = '{0, 0, 18'h00007, 18'h00007, 0, 3};
    tbl[3]  = '{1, 0, 18'h0,     18'h3FFFF, 1, 3};
    tbl[4]  = '{1, 1, 18'h0,     18'h00012, 2, 3};
    tbl[5]  = '{1, 0, 18'h0,     18'h00007, 0, 3};
    tbl[6]  = '{0, 0, 18'd1,     18'd1,     0, 4};
    tbl[7]  = '{0, 0, 18'd2,     18'd2,     0, 4};
    tbl[8]  = '{0, 1, 18'd3,     18'd3,     0, 4};
    tbl[9]  = '{0, 0, 18'd4,     18'd4,     0, 4};
    tbl[10] = '{0, 0, 18'd5,     18'd5,     0, 4};
    tbl[11] = '{0, 0, 18'd6,     18'd6,     0, 4};
    tbl[12] = '{1, 0, 18'h0,     18'd5,     1, 4};
    tbl[13] = '{1, 1, 18'h0,     18'd4,     2, 4};
    tbl[14] = '{1, 0, 18'h0,     18'd3,     3, 4};
    tbl[15] = '{1, 0, 18'h0,     18'd6,     0, 4};

    RST_N = 1'b0; i_valid = 1'b0; i_data = '0; i_key_n = 1'b1; i_dec = 1'b0;
    msel = 0;
    tick(3);
    check("rst_score", o_score, 0);
    check("rst_sel",   o_sel,   0);
    check("rst_count", o_count, 0);
    check("rst_busy",  o_busy,  0);
    check("rst_seven", o_seven, exp_seven(0, 0));
    RST_N = 1'b1;
    tick(SETTLE);
    check("post_rst_seven", o_seven, exp_seven(0, 0));

    // Capture and paging table
    foreach (tbl[i]) begin
      i_dec = tbl[i].dec;
      if (tbl[i].key) begin
        do_key();
      end else begin
        do_valid(tbl[i].data);
        check($sformatf("tbl%0d_score_1cyc", i), o_score, tbl[i].score);
      end
      tick(SETTLE);
      check($sformatf("tbl%0d_score", i), o_score, tbl[i].score);
      check($sformatf("tbl%0d_sel", i),   o_sel,   tbl[i].sel);
      check($sformatf("tbl%0d_count", i), o_count, tbl[i].cnt);
      check($sformatf("tbl%0d_seven", i), o_seven, exp_seven(tbl[i].score, tbl[i].dec));
      check($sformatf("tbl%0d_busy", i),  o_busy,  0);
    end

    // Decimal conversion of the largest score
    i_dec = 1'b1;
    tick(SETTLE);
    prev_seven = o_seven;
    do_valid(18'd262143);
    busy_n = 0;
    seen_busy = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (o_busy) begin
        if (!seen_busy) check("dec_hold_seven", o_seven, prev_seven);
        seen_busy = 1'b1;
        busy_n++;
      end
    end
    check("dec_busy_cycles", busy_n, DATA_W);
    check("dec_seven", o_seven, exp_seven(262143, 1));
    check("dec_low6", o_seven[41:0], {7'h24, 7'h02, 7'h24, 7'h79, 7'h19, 7'h30});
`ifdef SW_LEADING_ZERO_BLANK_EN
    check("dec_top2", o_seven[55:42], {7'h7F, 7'h7F});
`else
    check("dec_top2", o_seven[55:42], {7'h40, 7'h40});
`endif

    // Bouncing press must not step
    i_dec = 1'b0;
    foreach (prev_seven[b]) begin end
    for (int b = 0; b < 10; b++) begin
      i_key_n = (b == 2 || b == 4 || b >= 7);
      tick();
    end
    i_key_n = 1'b1;
    tick(DEB_CYC + 6);
    check("bounce_sel", o_sel, 0);

    // Clean press: one step, measure pulse latency, long hold adds nothing
    i_key_n = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (o_sel != 2'd0) begin
        lat = c;
        break;
      end
    end
    check("key_latency_in_range", (lat >= DEB_CYC + 1 && lat <= DEB_CYC + 5), 1);
    held_ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (o_sel != 2'd1) held_ok = 1'b0;
    end
    check("held_sel_stays_1", {held_ok, 6'd0, o_sel}, {1'b1, 6'd0, 2'd1});
    i_key_n = 1'b1;
    tick(DEB_CYC + 6);
    msel = 1;
    tick(SETTLE);
    check_model("press");

    // Capture coinciding with the accepted key pulse
    if (lat < 2) lat = DEB_CYC + 3;
    i_key_n = 1'b0;
    tick(lat - 1);
    do_valid(18'd9);
    tick(20);
    i_key_n = 1'b1;
    tick(DEB_CYC + 6 + SETTLE);
    check("coinc_sel", o_sel, 0);
    check("coinc_score", o_score, 9);
    check_model("coinc");

    // Reset in the middle of a decimal conversion
    i_dec = 1'b1;
    do_valid(18'd12345);
    seen_busy = 1'b0;
    for (int c = 0; c < 10 && !seen_busy; c++) begin
      tick();
      seen_busy = o_busy;
    end
    check("midconv_busy_seen", seen_busy, 1);
    #2 RST_N = 1'b0;
    #1;
    check("midrst_busy",  o_busy,  0);
    check("midrst_count", o_count, 0);
    check("midrst_score", o_score, 0);
    tick(2);
    RST_N = 1'b1;
    hq.delete();
    msel = 0;
    tick(SETTLE);
    check("midrst_seven", o_seven, exp_seven(0, 1));
    check_model("midrst");

    // Randomized traffic against the model
    for (int r = 0; r < 30; r++) begin
      int op;
      i_dec = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 3);
      if (op == 0)      do_valid(DATA_W'($urandom));
      else if (op == 1) do_valid(DATA_W'($urandom_range(0, 20)));
      else              do_key();
      tick(SETTLE);
      check_model($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
